// File: rtl/hw4alu_pkg.sv
// rtl/hw4alu_pkg.sv - shared hw4alu widths, function codes and result entry type
package hw4alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_NOT = 3'd5;
  localparam logic [2:0] F_SHL = 3'd6;
  localparam logic [2:0] F_SHR = 3'd7;

  typedef struct packed {
    logic             cout;
    logic             zero;
    logic             neg;
    logic [ALU_W-1:0] data;
  } alu_result_t;

endpackage

// File: rtl/hw4alu_fifo_mem.sv
// rtl/hw4alu_fifo_mem.sv - result entry storage, one write port, async read port
module hw4alu_fifo_mem
  import hw4alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  alu_result_t   wdata,
  input  logic [AW-1:0] raddr,
  output alu_result_t   rdata
);

  alu_result_t mem [DEPTH];

  // Data is deliberately unreset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hw4alu_result_fifo.sv
// rtl/hw4alu_result_fifo.sv - ALU result capture FIFO with flags and running checksum
module hw4alu_result_fifo
  import hw4alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         q,
  input  logic                     cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_cout,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     csum_clr,
  output logic [15:0]              csum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [15:0]   contrib;
  alu_result_t   wr_entry, rd_entry;

  // Handshake depends on registered count only, never on out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_entry      = '0;
    wr_entry.cout = cout;
    wr_entry.zero = (q == '0);
    wr_entry.neg  = q[WIDTH-1];
    wr_entry.data = q;
  end

  assign contrib = 16'(q) + 16'(cout);

  hw4alu_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign out_data = out_valid ? rd_entry.data : '0;
  assign out_cout = out_valid && rd_entry.cout;
  assign out_zero = out_valid && rd_entry.zero;
  assign out_neg  = out_valid && rd_entry.neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A clear coinciding with a push restarts the sum at that push's contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (csum_clr) begin
      csum <= push ? contrib : 16'h0000;
    end else if (push) begin
      csum <= csum + contrib;
    end
  end

endmodule

// File: doc/hw4alu_result_fifo.md
# hw4alu_result_fifo

Downstream capture stage for the 8-bit `hw4alu`: accepts each ALU result (`Q`, `Cout`) under a valid/ready handshake. Each accepted result is stored with derived zero/negative flags in a small FIFO and presented to the consumer in arrival order. The block also keeps a running 16-bit checksum of accepted results. It decouples the combinational ALU from a slower consumer, such as a register-file write port or a bus.

## Interface
- `WIDTH`, 8: result width; matches the ALU `Q` width.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  the ALU result on `q`/`cout` is offered.
- `in_ready`  out  1  the FIFO can accept this cycle.
- `q`  in  WIDTH  ALU result.
- `cout`  in  1  ALU carry-out.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  the consumer takes the head this cycle.
- `out_data`  out  WIDTH  head result.
- `out_cout`  out  1  head carry.
- `out_zero`  out  1  head result == 0.
- `out_neg`  out  1  head result MSB.
- `count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `csum_clr`  in  1  synchronous clear of the checksum.
- `csum`  out  16  running checksum.

## Operation
- Push when `in_valid && in_ready`. The stored entry is {`cout`, `q==0`, `q[WIDTH-1]`, `q`}. Flags are computed at push, not at pop.
- Pop when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. This is registered-state-derived only; there is no combinational path from `out_ready`.
- `out_valid = (count != 0)`. The `out_*` fields always show the head entry and are held stable while `out_valid && !out_ready`.
- Simultaneous push and pop:
  - When 0 < count < DEPTH: `count` is unchanged and both pointers advance.
  - When count == 0: only the push occurs.
  - When count == DEPTH: only the pop occurs, because `in_ready` is 0.
- Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by the explicit `count` register.
- Checksum: on each push, `csum <= csum + {8'h00, q} + cout` (mod 2^16, wraps silently).
  - `csum_clr` has priority. If a push coincides with a clear, `csum` becomes that push's contribution.
- Data in unoccupied entries is don't-care. Outputs `out_data`/flags are forced to 0 when `out_valid` = 0.

## Timing
- Async reset when `rst_n` is low, effective immediately:
  - `count` = 0, pointers = 0, `csum` = 0.
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_cout` = `out_zero` = `out_neg` = 0.
- Reset mid-operation discards all entries. No handshake completes in the cycle where `rst_n` is low. Normal operation resumes on the first rising edge after deassertion.
- Latency: a push at edge N gives `out_valid` = 1 after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- All state changes occur on the `clk` rising edge only. Outputs are glitch-free functions of registers.

## Structure
- Shared package `hw4alu_pkg`:
  - `ALU_W` = 8.
  - ALU function-code constants (3-bit `F` encodings).
  - The typedef `alu_result_t` = packed {cout, zero, neg, data[ALU_W-1:0]}.
- One sub-module, `hw4alu_fifo_mem`: DEPTH x `alu_result_t` register array with one write port and one asynchronous read port, no reset on data.
- The top level holds the pointers, `count`, handshake logic, flag generation and checksum.

## Test plan
- Reset, then push Q=8'hA3 with cout=0 (sum of 8'h6D+8'h36) -> one cycle later `out_valid`=1, `out_data`=A3, `out_neg`=1, `out_zero`=0, `count`=1, `csum`=16'h00A3.
- Push 4 results (A3, 37, 00, FF with cout=1 on the last) with `out_ready`=0 -> after the 4th push `count`=4 and `in_ready`=0; a 5th offered value is not accepted. Then drain with `out_ready`=1 -> the consumer sees the values in order, with `out_zero`=1 on 00 and `out_cout`=1 on FF.
- Continuous push and pop each cycle at count=2 for 10 cycles -> `count` stays at 2, pointers wrap past DEPTH, and data order is preserved.
- Push FF with cout=1 repeatedly until the checksum passes 16'hFFFF -> it wraps modulo 2^16. Assert `csum_clr` together with a push of 05 -> `csum`=16'h0005.
- Assert `rst_n`=0 asynchronously (between clock edges) with count=3 -> immediately `out_valid`=0, `count`=0, `in_ready`=1, `csum`=0. After release, the first push behaves as in the first scenario.
